// File: rtl/mc_ctrl_pkg.sv
// Shared encodings for the multicycle control unit: FSM states, opcodes, ALU operations
// and datapath mux selects.
package mc_ctrl_pkg;

    // Values are fixed so that state_o reads back the same on every build.
    typedef enum logic [3:0] {
        StFetch  = 4'd0,
        StDecode = 4'd1,
        StMemAdr = 4'd2,
        StMemRd  = 4'd3,
        StMemWb  = 4'd4,
        StMemWr  = 4'd5,
        StExecR  = 4'd6,
        StExecI  = 4'd7,
        StAluWb  = 4'd8,
        StBranch = 4'd9,
        StJal    = 4'd10,
        StJalr   = 4'd11,
        StLui    = 4'd12,
        StAuipc  = 4'd13,
        StMulDiv = 4'd14,
        StTrap   = 4'd15
    } state_e;

    localparam logic [6:0] OpLoad   = 7'b0000011;
    localparam logic [6:0] OpStore  = 7'b0100011;
    localparam logic [6:0] OpR      = 7'b0110011;
    localparam logic [6:0] OpImm    = 7'b0010011;
    localparam logic [6:0] OpBranch = 7'b1100011;
    localparam logic [6:0] OpJal    = 7'b1101111;
    localparam logic [6:0] OpJalr   = 7'b1100111;
    localparam logic [6:0] OpLui    = 7'b0110111;
    localparam logic [6:0] OpAuipc  = 7'b0010111;

    localparam logic [6:0] Funct7Base   = 7'b0000000;
    localparam logic [6:0] Funct7Alt    = 7'b0100000;
    localparam logic [6:0] Funct7MulDiv = 7'b0000001;

    // Request from the FSM to the ALU sub-decoder.
    typedef enum logic [1:0] {
        AluOpAdd    = 2'd0,
        AluOpSub    = 2'd1,
        AluOpFunct  = 2'd2,
        AluOpBranch = 2'd3
    } alu_op_e;

    localparam logic [3:0] AluAdd  = 4'd0;
    localparam logic [3:0] AluSub  = 4'd1;
    localparam logic [3:0] AluAnd  = 4'd2;
    localparam logic [3:0] AluOr   = 4'd3;
    localparam logic [3:0] AluXor  = 4'd4;
    localparam logic [3:0] AluSll  = 4'd5;
    localparam logic [3:0] AluSrl  = 4'd6;
    localparam logic [3:0] AluSra  = 4'd7;
    localparam logic [3:0] AluSlt  = 4'd8;
    localparam logic [3:0] AluSltu = 4'd9;

    localparam logic [2:0] ImmI = 3'd0;
    localparam logic [2:0] ImmS = 3'd1;
    localparam logic [2:0] ImmB = 3'd2;
    localparam logic [2:0] ImmJ = 3'd3;
    localparam logic [2:0] ImmU = 3'd4;

    localparam logic [1:0] ResAluOut    = 2'd0;
    localparam logic [1:0] ResMemData   = 2'd1;
    localparam logic [1:0] ResAluResult = 2'd2;
    localparam logic [1:0] ResImmExt    = 2'd3;

    localparam logic [1:0] SrcAPc    = 2'd0;
    localparam logic [1:0] SrcAOldPc = 2'd1;
    localparam logic [1:0] SrcARs1   = 2'd2;

    localparam logic [1:0] SrcBRs2   = 2'd0;
    localparam logic [1:0] SrcBImm   = 2'd1;
    localparam logic [1:0] SrcBFour  = 2'd2;

    // Base R-type allows funct7 = 0, plus 0100000 only for SUB and SRA.
    function automatic logic r_funct7_legal(input logic [2:0] funct3, input logic [6:0] funct7);
        return (funct7 == Funct7Base) ||
               ((funct7 == Funct7Alt) && ((funct3 == 3'b000) || (funct3 == 3'b101)));
    endfunction

endpackage

// File: rtl/mc_alu_decoder.sv
// ALU sub-decoder: turns the FSM's ALU request plus funct fields into an ALU operation.
module mc_alu_decoder
    import mc_ctrl_pkg::*;
(
    input  alu_op_e    alu_op_i,
    input  logic [2:0] funct3_i,
    input  logic       funct7_5_i,
    input  logic       is_rtype_i,
    output logic [3:0] alu_ctrl_o
);

    // Decode the ALU operation; funct7[5] only matters for R-type SUB and for SRA/SRAI.
    always_comb begin
        alu_ctrl_o = AluAdd;
        unique case (alu_op_i)
            AluOpAdd: alu_ctrl_o = AluAdd;
            AluOpSub: alu_ctrl_o = AluSub;
            AluOpBranch: begin
                // funct3[2] selects a magnitude compare, funct3[1] its unsigned flavour.
                if (!funct3_i[2])     alu_ctrl_o = AluSub;
                else if (funct3_i[1]) alu_ctrl_o = AluSltu;
                else                  alu_ctrl_o = AluSlt;
            end
            AluOpFunct: begin
                unique case (funct3_i)
                    3'b000:  alu_ctrl_o = (is_rtype_i && funct7_5_i) ? AluSub : AluAdd;
                    3'b001:  alu_ctrl_o = AluSll;
                    3'b010:  alu_ctrl_o = AluSlt;
                    3'b011:  alu_ctrl_o = AluSltu;
                    3'b100:  alu_ctrl_o = AluXor;
                    3'b101:  alu_ctrl_o = funct7_5_i ? AluSra : AluSrl;
                    3'b110:  alu_ctrl_o = AluOr;
                    default: alu_ctrl_o = AluAnd;
                endcase
            end
            default: alu_ctrl_o = AluAdd;
        endcase
    end

endmodule

// File: rtl/multicycle_control_unit.sv
// Multicycle RISC-V control FSM: sequences fetch/decode/execute/memory/writeback,
// resolves branches per funct3, handshakes with an optional mul/div unit and traps.
module multicycle_control_unit
    import mc_ctrl_pkg::*;
#(
    parameter bit          SUPPORT_M      = 1'b1,
    parameter int unsigned ALU_CTRL_W     = 4,
    parameter int unsigned IMM_SRC_W      = 3,
    parameter int unsigned MULDIV_TIMEOUT = 64
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [6:0]            opcode,
    input  logic [2:0]            funct3,
    input  logic [6:0]            funct7,
    input  logic                  zero,
    input  logic                  comparison,
    input  logic                  muldiv_done,
    output logic                  PCWrite,
    output logic                  AdrSrc,
    output logic                  IRWrite,
    output logic                  MemWrite,
    output logic                  MemRead,
    output logic                  RegWrite,
    output logic [1:0]            ResultSrc,
    output logic [1:0]            ALUSrcA,
    output logic [1:0]            ALUSrcB,
    output logic [IMM_SRC_W-1:0]  ImmSrc,
    output logic [ALU_CTRL_W-1:0] ALUControl,
    output logic                  muldiv_start,
    output logic                  trap,
    output logic [3:0]            state_o
);

    localparam int unsigned CntW = (MULDIV_TIMEOUT > 1) ? $clog2(MULDIV_TIMEOUT) : 1;
    localparam logic [CntW-1:0] CntMax = CntW'(MULDIV_TIMEOUT - 1);

    state_e          state_q, state_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic            first_q, first_d;

    alu_op_e         alu_op;
    logic [3:0]      alu_ctrl;
    logic [2:0]      imm_src;
    logic            timeout_hit;

    mc_alu_decoder u_alu_decoder (
        .alu_op_i   (alu_op),
        .funct3_i   (funct3),
        .funct7_5_i (funct7[5]),
        .is_rtype_i (opcode[5]),
        .alu_ctrl_o (alu_ctrl)
    );

    assign timeout_hit = (MULDIV_TIMEOUT != 0) && (cnt_q == CntMax);

    // State, mul/div wait counter and start-pulse flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StFetch;
            cnt_q   <= '0;
            first_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            first_q <= first_d;
        end
    end

    // Next state and Moore outputs; PCWrite in BRANCH also depends on the ALU flags.
    always_comb begin
        state_d      = state_q;
        cnt_d        = '0;
        PCWrite      = 1'b0;
        AdrSrc       = 1'b0;
        IRWrite      = 1'b0;
        MemWrite     = 1'b0;
        MemRead      = 1'b0;
        RegWrite     = 1'b0;
        ResultSrc    = ResAluOut;
        ALUSrcA      = SrcAPc;
        ALUSrcB      = SrcBRs2;
        imm_src      = ImmI;
        alu_op       = AluOpAdd;
        muldiv_start = 1'b0;
        trap         = 1'b0;

        unique case (state_q)
            StFetch: begin
                MemRead   = 1'b1;
                IRWrite   = 1'b1;
                ALUSrcB   = SrcBFour;
                ResultSrc = ResAluResult;
                PCWrite   = 1'b1;
                state_d   = StDecode;
            end
            StDecode: begin
                // Precompute the branch target into ALUOut.
                ALUSrcA = SrcAOldPc;
                ALUSrcB = SrcBImm;
                imm_src = ImmB;
                unique case (opcode)
                    OpLoad, OpStore: state_d = StMemAdr;
                    OpR: begin
                        if (SUPPORT_M && (funct7 == Funct7MulDiv)) state_d = StMulDiv;
                        else if (r_funct7_legal(funct3, funct7))  state_d = StExecR;
                        else                                      state_d = StTrap;
                    end
                    OpImm:    state_d = StExecI;
                    OpBranch: state_d = StBranch;
                    OpJal:    state_d = StJal;
                    OpJalr:   state_d = StJalr;
                    OpLui:    state_d = StLui;
                    OpAuipc:  state_d = StAuipc;
                    default:  state_d = StTrap;
                endcase
            end
            StMemAdr: begin
                ALUSrcA = SrcARs1;
                ALUSrcB = SrcBImm;
                imm_src = (opcode == OpStore) ? ImmS : ImmI;
                state_d = (opcode == OpStore) ? StMemWr : StMemRd;
            end
            StMemRd: begin
                AdrSrc  = 1'b1;
                MemRead = 1'b1;
                state_d = StMemWb;
            end
            StMemWb: begin
                ResultSrc = ResMemData;
                RegWrite  = 1'b1;
                state_d   = StFetch;
            end
            StMemWr: begin
                AdrSrc   = 1'b1;
                MemWrite = 1'b1;
                state_d  = StFetch;
            end
            StExecR, StExecI: begin
                ALUSrcA = SrcARs1;
                ALUSrcB = (state_q == StExecR) ? SrcBRs2 : SrcBImm;
                imm_src = ImmI;
                alu_op  = AluOpFunct;
                state_d = StAluWb;
            end
            StAluWb: begin
                ResultSrc = ResAluOut;
                RegWrite  = 1'b1;
                state_d   = StFetch;
            end
            StBranch: begin
                ALUSrcA   = SrcARs1;
                ALUSrcB   = SrcBRs2;
                ResultSrc = ResAluOut;
                alu_op    = AluOpBranch;
                state_d   = StFetch;
                unique case (funct3)
                    3'b000:         PCWrite = zero;
                    3'b001:         PCWrite = ~zero;
                    3'b100, 3'b110: PCWrite = comparison;
                    3'b101, 3'b111: PCWrite = ~comparison;
                    default:        state_d = StTrap;
                endcase
            end
            StJal: begin
                ALUSrcA   = SrcAOldPc;
                ALUSrcB   = SrcBFour;
                ResultSrc = ResAluOut;
                imm_src   = ImmJ;
                PCWrite   = 1'b1;
                state_d   = StAluWb;
            end
            StJalr: begin
                ALUSrcA   = SrcARs1;
                ALUSrcB   = SrcBImm;
                imm_src   = ImmI;
                ResultSrc = ResAluResult;
                PCWrite   = 1'b1;
                state_d   = StAluWb;
            end
            StLui: begin
                imm_src   = ImmU;
                ResultSrc = ResImmExt;
                RegWrite  = 1'b1;
                state_d   = StFetch;
            end
            StAuipc: begin
                ALUSrcA = SrcAOldPc;
                ALUSrcB = SrcBImm;
                imm_src = ImmU;
                state_d = StAluWb;
            end
            StMulDiv: begin
                muldiv_start = first_q;
                cnt_d        = cnt_q + CntW'(1);
                // A done arriving on the timeout cycle still completes the instruction.
                if (muldiv_done) begin
                    ResultSrc = ResAluResult;
                    RegWrite  = 1'b1;
                    state_d   = StFetch;
                end else if (timeout_hit) begin
                    state_d = StTrap;
                end
            end
            StTrap: begin
                trap    = 1'b1;
                state_d = StTrap;
            end
            default: state_d = StTrap;
        endcase

        first_d = (state_q != StMulDiv) && (state_d == StMulDiv);
    end

    assign ImmSrc     = IMM_SRC_W'(imm_src);
    assign ALUControl = ALU_CTRL_W'(alu_ctrl);
    assign state_o    = state_q;

endmodule

// File: tb/tb_multicycle_control_unit.sv
// Directed bench for the multicycle control unit. A second instance built without the
// M extension shares the stimulus so mul decoding can be checked as illegal there.
module tb_multicycle_control_unit;
    import mc_ctrl_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst;
    logic [6:0] opcode;
    logic [2:0] funct3;
    logic [6:0] funct7;
    logic       zero, comparison, muldiv_done;

    logic       pc_write, adr_src, ir_write, mem_write, mem_read, reg_write;
    logic [1:0] result_src, alu_src_a, alu_src_b;
    logic [2:0] imm_src;
    logic [3:0] alu_control;
    logic       muldiv_start, trap;
    logic [3:0] state;

    logic       n_pc_write, n_adr_src, n_ir_write, n_mem_write, n_mem_read, n_reg_write;
    logic [1:0] n_result_src, n_alu_src_a, n_alu_src_b;
    logic [2:0] n_imm_src;
    logic [3:0] n_alu_control;
    logic       n_muldiv_start, n_trap;
    logic [3:0] n_state;

    int n_checks = 0;
    int n_pass   = 0;
    int starts;
    int mcycles;
    int hit;
    logic [3:0] held;

    multicycle_control_unit #(
        .SUPPORT_M      (1'b1),
        .ALU_CTRL_W     (4),
        .IMM_SRC_W      (3),
        .MULDIV_TIMEOUT (8)
    ) dut (
        .clk(clk), .rst(rst), .opcode(opcode), .funct3(funct3), .funct7(funct7),
        .zero(zero), .comparison(comparison), .muldiv_done(muldiv_done),
        .PCWrite(pc_write), .AdrSrc(adr_src), .IRWrite(ir_write), .MemWrite(mem_write),
        .MemRead(mem_read), .RegWrite(reg_write), .ResultSrc(result_src),
        .ALUSrcA(alu_src_a), .ALUSrcB(alu_src_b), .ImmSrc(imm_src),
        .ALUControl(alu_control), .muldiv_start(muldiv_start), .trap(trap),
        .state_o(state)
    );

    multicycle_control_unit #(
        .SUPPORT_M      (1'b0),
        .ALU_CTRL_W     (4),
        .IMM_SRC_W      (3),
        .MULDIV_TIMEOUT (8)
    ) dut_nom (
        .clk(clk), .rst(rst), .opcode(opcode), .funct3(funct3), .funct7(funct7),
        .zero(zero), .comparison(comparison), .muldiv_done(muldiv_done),
        .PCWrite(n_pc_write), .AdrSrc(n_adr_src), .IRWrite(n_ir_write),
        .MemWrite(n_mem_write), .MemRead(n_mem_read), .RegWrite(n_reg_write),
        .ResultSrc(n_result_src), .ALUSrcA(n_alu_src_a), .ALUSrcB(n_alu_src_b),
        .ImmSrc(n_imm_src), .ALUControl(n_alu_control), .muldiv_start(n_muldiv_start),
        .trap(n_trap), .state_o(n_state)
    );

    task automatic check(input string tag, input int got, input int exp);
        n_checks++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic load(input logic [6:0] op, input logic [2:0] f3, input logic [6:0] f7);
        opcode = op;
        funct3 = f3;
        funct7 = f7;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step();
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        load(7'b0000000, 3'b000, 7'b0000000);
        zero = 1'b0; comparison = 1'b0; muldiv_done = 1'b0;

        // Reset: FETCH outputs both in the reset cycle and after it.
        step();
        check("rst_state", state, StFetch);
        check("rst_trap", trap, 0);
        check("rst_pcwrite", pc_write, 1);
        check("rst_memread", mem_read, 1);
        check("rst_irwrite", ir_write, 1);
        check("rst_alusrcb", alu_src_b, 2);
        check("rst_resultsrc", result_src, 2);
        check("rst_regwrite", reg_write, 0);
        rst = 1'b0;

        // add: FETCH, DECODE, EXEC_R, ALUWB, FETCH
        load(OpR, 3'b000, 7'b0000000);
        step();
        check("add_c2_state", state, StDecode);
        check("add_c2_alusrca", alu_src_a, 1);
        check("add_c2_immsrc", imm_src, 2);
        check("add_c2_regwrite", reg_write, 0);
        step();
        check("add_c3_state", state, StExecR);
        check("add_c3_aluctl", alu_control, AluAdd);
        check("add_c3_alusrca", alu_src_a, 2);
        check("add_c3_alusrcb", alu_src_b, 0);
        check("add_c3_regwrite", reg_write, 0);
        step();
        check("add_c4_state", state, StAluWb);
        check("add_c4_regwrite", reg_write, 1);
        check("add_c4_resultsrc", result_src, 0);
        step();
        check("add_c5_state", state, StFetch);

        // sub: same path, ALU op must become SUB
        load(OpR, 3'b000, 7'b0100000);
        step(); step();
        check("sub_aluctl", alu_control, AluSub);
        step(); step();

        // lw: 5 cycles
        load(OpLoad, 3'b010, 7'b0000000);
        check("lw_c1_memread", mem_read, 1);
        step();
        check("lw_c2_memread", mem_read, 0);
        step();
        check("lw_c3_state", state, StMemAdr);
        check("lw_c3_immsrc", imm_src, 0);
        check("lw_c3_alusrca", alu_src_a, 2);
        step();
        check("lw_c4_state", state, StMemRd);
        check("lw_c4_memread", mem_read, 1);
        check("lw_c4_adrsrc", adr_src, 1);
        check("lw_c4_regwrite", reg_write, 0);
        step();
        check("lw_c5_regwrite", reg_write, 1);
        check("lw_c5_resultsrc", result_src, 1);
        step();
        check("lw_end_state", state, StFetch);

        // sw: 4 cycles
        load(OpStore, 3'b010, 7'b0000000);
        step(); step();
        check("sw_c3_immsrc", imm_src, 1);
        check("sw_c3_memwrite", mem_write, 0);
        step();
        check("sw_c4_state", state, StMemWr);
        check("sw_c4_memwrite", mem_write, 1);
        step();
        check("sw_end_state", state, StFetch);
        check("sw_end_memwrite", mem_write, 0);

        // bne / bgeu: PCWrite is combinational on the flags in BRANCH
        load(OpBranch, 3'b001, 7'b0000000);
        step(); step();
        check("bne_state", state, StBranch);
        check("bne_aluctl", alu_control, AluSub);
        zero = 1'b1; #1;
        check("bne_zero1_pcwrite", pc_write, 0);
        zero = 1'b0; #1;
        check("bne_zero0_pcwrite", pc_write, 1);
        step();
        check("bne_end_state", state, StFetch);
        load(OpBranch, 3'b111, 7'b0000000);
        step(); step();
        check("bgeu_aluctl", alu_control, AluSltu);
        comparison = 1'b1; #1;
        check("bgeu_cmp1_pcwrite", pc_write, 0);
        comparison = 1'b0; #1;
        check("bgeu_cmp0_pcwrite", pc_write, 1);
        step();

        // lui: writeback of ImmExt in the third cycle
        load(OpLui, 3'b000, 7'b0000000);
        step(); step();
        check("lui_state", state, StLui);
        check("lui_regwrite", reg_write, 1);
        check("lui_resultsrc", result_src, 3);
        check("lui_immsrc", imm_src, 4);
        step();

        // mul: done pulsed 5 cycles after entry, 8 cycles in all
        load(OpR, 3'b000, 7'b0000001);
        check("mul_c1_state", state, StFetch);
        step();
        starts = 0;
        for (int c = 3; c <= 7; c++) begin
            step();
            starts += int'(muldiv_start);
            check("mul_wait_state", state, StMulDiv);
            check("mul_wait_start", muldiv_start, (c == 3) ? 1 : 0);
            check("mul_wait_regwrite", reg_write, 0);
        end
        step();
        muldiv_done = 1'b1; #1;
        starts += int'(muldiv_start);
        check("mul_c8_state", state, StMulDiv);
        check("mul_c8_regwrite", reg_write, 1);
        check("mul_c8_resultsrc", result_src, 2);
        check("mul_start_count", starts, 1);
        step();
        muldiv_done = 1'b0;
        check("mul_end_state", state, StFetch);
        check("nom_mul_state", n_state, StTrap);
        check("nom_mul_trap", n_trap, 1);

        // mul without done: trap after 8 MULDIV cycles
        step();
        mcycles = 0;
        hit = 0;
        for (int c = 0; c < 20 && hit == 0; c++) begin
            step();
            if (state == StMulDiv) mcycles++;
            else if (state == StTrap) hit = 1;
        end
        check("to_trapped", hit, 1);
        check("to_muldiv_cycles", mcycles, 8);
        held = state;
        for (int c = 0; c < 3; c++) begin
            step();
            check("to_hold_state", state, held);
            check("to_hold_trap", trap, 1);
            check("to_hold_pcwrite", pc_write, 0);
        end
        do_reset();
        check("to_rst_state", state, StFetch);
        check("to_rst_trap", trap, 0);
        check("nom_rst_trap", n_trap, 0);

        // Illegal opcode
        load(7'b1111111, 3'b000, 7'b0000000);
        step(); step();
        check("ill_op_trap", trap, 1);
        for (int c = 0; c < 3; c++) begin
            step();
            check("ill_op_hold", state, StTrap);
        end
        do_reset();
        check("ill_op_rst_state", state, StFetch);

        // Branch funct3 010
        load(OpBranch, 3'b010, 7'b0000000);
        step(); step();
        check("ill_br_pcwrite", pc_write, 0);
        step();
        check("ill_br_state", state, StTrap);
        check("ill_br_trap", trap, 1);
        do_reset();
        check("ill_br_rst_trap", trap, 0);

        // Reset during MEMRD aborts the load
        load(OpLoad, 3'b010, 7'b0000000);
        step(); step(); step();
        check("ab_ld_state", state, StMemRd);
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("ab_ld_state_after", state, StFetch);
        check("ab_ld_regwrite", reg_write, 0);
        check("ab_ld_memwrite", mem_write, 0);

        // Reset during MULDIV aborts the mul, no fresh start pulse
        load(OpR, 3'b000, 7'b0000001);
        step(); step();
        check("ab_mul_start", muldiv_start, 1);
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("ab_mul_state_after", state, StFetch);
        check("ab_mul_start_after", muldiv_start, 0);
        check("ab_mul_regwrite", reg_write, 0);
        load(OpImm, 3'b101, 7'b0100000);
        step();
        check("ab_mul_dec_start", muldiv_start, 0);
        step();
        check("srai_state", state, StExecI);
        check("srai_aluctl", alu_control, AluSra);
        check("srai_alusrcb", alu_src_b, 1);
        step();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
